// File: rtl/rst_seq_ctrl_pkg.sv
// Shared encodings and defaults for the peripheral reset sequencer.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int HOLD_CYCLES_DEF     = 64;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer.
// The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce
  import rst_seq_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RST_LEVEL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that matches the accepted level restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= {2{RST_LEVEL}};
      stable_q <= RST_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], async_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Peripheral reset sequencer: waits for clock lock and button release,
// holds reset for HOLD_CYCLES, then releases periph_rst and soc_erst_n.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic       clk_16M,
  input  logic       reset_periph,
  input  logic       mmcm_locked,
  input  logic       ext_rst_n,
  input  logic       wakeup_n_raw,
  output logic       periph_rst,
  output logic       soc_erst_n,
  output logic       dwakeup_n,
  output logic [1:0] seq_state,
  output logic [7:0] rst_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       lock_sync_q;
  logic             lock_s;
  logic             btn_db;
  seq_state_t       state_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             periph_rst_q;
  logic             soc_erst_n_q;
  logic [7:0]       rst_count_q;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b0)
  ) u_btn_db (
    .clk_i   (clk_16M),
    .rst_i   (reset_periph),
    .async_i (ext_rst_n),
    .level_o (btn_db)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b1)
  ) u_wake_db (
    .clk_i   (clk_16M),
    .rst_i   (reset_periph),
    .async_i (wakeup_n_raw),
    .level_o (dwakeup_n)
  );

  always_ff @(posedge clk_16M or posedge reset_periph) begin
    if (reset_periph) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], mmcm_locked};
    end
  end

  assign lock_s = lock_sync_q[1];

  // periph_rst tracks the next state so both change on the same edge.
  always_ff @(posedge clk_16M or posedge reset_periph) begin
    if (reset_periph) begin
      state_q      <= WAIT_LOCK;
      hold_cnt_q   <= '0;
      periph_rst_q <= 1'b1;
      soc_erst_n_q <= 1'b0;
      rst_count_q  <= '0;
    end else begin
      soc_erst_n_q <= ~periph_rst_q;
      case (state_q)
        WAIT_LOCK: begin
          hold_cnt_q   <= '0;
          periph_rst_q <= 1'b1;
          if (lock_s && btn_db) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!lock_s || !btn_db) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= RUN;
            hold_cnt_q   <= '0;
            periph_rst_q <= 1'b0;
            if (rst_count_q != 8'hFF) begin
              rst_count_q <= rst_count_q + 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s || !btn_db) begin
            state_q      <= WAIT_LOCK;
            periph_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= WAIT_LOCK;
          hold_cnt_q   <= '0;
          periph_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign periph_rst = periph_rst_q;
  assign soc_erst_n = soc_erst_n_q;
  assign seq_state  = state_q;
  assign rst_count  = rst_count_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_rst_seq_ctrl;

  logic       clk_16M      = 1'b0;
  logic       reset_periph = 1'b1;
  logic       mmcm_locked  = 1'b0;
  logic       ext_rst_n    = 1'b0;
  logic       wakeup_n_raw = 1'b1;
  logic       periph_rst;
  logic       soc_erst_n;
  logic       dwakeup_n;
  logic [1:0] seq_state;
  logic [7:0] rst_count;

  int errors = 0;
  int checks = 0;

  rst_seq_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk_16M      (clk_16M),
    .reset_periph (reset_periph),
    .mmcm_locked  (mmcm_locked),
    .ext_rst_n    (ext_rst_n),
    .wakeup_n_raw (wakeup_n_raw),
    .periph_rst   (periph_rst),
    .soc_erst_n   (soc_erst_n),
    .dwakeup_n    (dwakeup_n),
    .seq_state    (seq_state),
    .rst_count    (rst_count)
  );

  always #5 clk_16M = ~clk_16M;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_16M);
  endtask

  // Negedge index (from the call) at which HOLD is first seen and periph_rst falls.
  task automatic run_timed(output int t_hold, output int t_run);
    t_hold = -1;
    t_run  = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_16M);
      if (seq_state == 2'd1 && t_hold < 0) t_hold = c;
      if (!periph_rst) begin
        t_run = c;
        break;
      end
    end
  endtask

  task automatic wait_periph(input string tag, input logic val, input int limit);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_16M);
      if (periph_rst == val) break;
    end
    check_val(tag, periph_rst, val);
  endtask

  initial begin
    int t_hold;
    int t_run;

    step(3);
    check_val("rst_state", seq_state, 0);
    check_val("rst_periph", periph_rst, 1);
    check_val("rst_soc", soc_erst_n, 0);
    check_val("rst_dwake", dwakeup_n, 1);
    check_val("rst_count", rst_count, 0);

    reset_periph = 1'b0;
    step(3);
    check_val("idle_state", seq_state, 0);
    check_val("idle_periph", periph_rst, 1);

    mmcm_locked = 1'b1;
    ext_rst_n   = 1'b1;
    run_timed(t_hold, t_run);
    check_val("seq1_hold_at", t_hold, 7);
    check_val("seq1_run_at", t_run, 15);
    check_val("seq1_soc_lag", soc_erst_n, 0);
    check_val("seq1_count", rst_count, 1);
    step(1);
    check_val("seq1_soc", soc_erst_n, 1);

    ext_rst_n = 1'b0;
    step(3);
    ext_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_val("glitch_state", seq_state, 2);
      check_val("glitch_periph", periph_rst, 0);
      check_val("glitch_soc", soc_erst_n, 1);
    end

    ext_rst_n = 1'b0;
    step(4);
    ext_rst_n = 1'b1;
    step(2);
    check_val("btn4_pre", periph_rst, 0);
    step(1);
    check_val("btn4_periph", periph_rst, 1);
    check_val("btn4_state", seq_state, 0);
    run_timed(t_hold, t_run);
    check_val("btn4_hold_at", t_hold, 4);
    check_val("btn4_run_at", t_run, 12);
    check_val("btn4_count", rst_count, 2);
    step(1);

    mmcm_locked = 1'b0;
    step(2);
    check_val("lockdrop_pre", periph_rst, 0);
    step(1);
    check_val("lockdrop_periph", periph_rst, 1);
    check_val("lockdrop_state", seq_state, 0);
    check_val("lockdrop_soc_lag", soc_erst_n, 1);
    check_val("lockdrop_dwake", dwakeup_n, 1);
    step(1);
    check_val("lockdrop_soc", soc_erst_n, 0);

    mmcm_locked = 1'b1;
    step(3);
    check_val("abort_in_hold", seq_state, 1);
    step(4);
    mmcm_locked = 1'b0;
    step(2);
    check_val("abort_still_hold", seq_state, 1);
    step(1);
    check_val("abort_state", seq_state, 0);
    check_val("abort_periph", periph_rst, 1);
    check_val("abort_count", rst_count, 3 - 1);
    step(2);
    mmcm_locked = 1'b1;
    run_timed(t_hold, t_run);
    check_val("relock_hold_at", t_hold, 3);
    check_val("relock_run_at", t_run, 11);
    check_val("relock_count", rst_count, 3);
    step(1);

    wakeup_n_raw = 1'b0;
    step(5);
    check_val("wake_pre", dwakeup_n, 1);
    step(1);
    check_val("wake_low", dwakeup_n, 0);
    check_val("wake_state", seq_state, 2);
    wakeup_n_raw = 1'b1;
    step(5);
    check_val("wake_hold_low", dwakeup_n, 0);
    step(1);
    check_val("wake_high", dwakeup_n, 1);
    check_val("wake_state2", seq_state, 2);
    check_val("wake_periph", periph_rst, 0);

    for (int i = 0; i < 260; i++) begin
      int exp_cnt;
      exp_cnt = (4 + i > 255) ? 255 : 4 + i;
      mmcm_locked = 1'b0;
      wait_periph("sat_drop", 1'b1, 10);
      mmcm_locked = 1'b1;
      wait_periph("sat_run", 1'b0, 30);
      check_val("sat_count", rst_count, exp_cnt);
    end

    wakeup_n_raw = 1'b0;
    step(8);
    check_val("pre_rst_dwake", dwakeup_n, 0);
    mmcm_locked = 1'b0;
    step(3);
    check_val("pre_rst_periph", periph_rst, 1);
    mmcm_locked = 1'b1;
    step(5);
    check_val("pre_rst_hold", seq_state, 1);
    check_val("pre_rst_count", rst_count, 255);
    #1 reset_periph = 1'b1;
    #1;
    check_val("midrst_state", seq_state, 0);
    check_val("midrst_periph", periph_rst, 1);
    check_val("midrst_soc", soc_erst_n, 0);
    check_val("midrst_dwake", dwakeup_n, 1);
    check_val("midrst_count", rst_count, 0);
    step(1);
    reset_periph = 1'b0;
    run_timed(t_hold, t_run);
    check_val("post_rst_hold_at", t_hold, 7);
    check_val("post_rst_run_at", t_run, 15);
    check_val("post_rst_count", rst_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
